// File: rtl/addsub_nibble_seq.sv
// Multi-cycle add/subtract engine: one shared SLICE-bit adder walks the operands
// LSB slice first, carrying between slices in a register.
module addsub_nibble_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             c_out,
    output logic             overflow
);

    // WIDTH must be an integer multiple of SLICE.
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [31:0]      base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   sum_w;
    logic             cin_msb;

    // Shared slice adder; carry into the slice MSB is recovered from the sum bit.
    assign base    = 32'(idx) * 32'(SLICE);
    assign a_sl    = a_r[base +: SLICE];
    assign b_sl    = b_r[base +: SLICE];
    assign sum_w   = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE + 1)'(carry);
    assign cin_msb = sum_w[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == IDXW'(NSLICE - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs follow the next state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    // Operand capture and slice-by-slice result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            res      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= op_sub ? ~b : b;
            carry <= op_sub;
            idx   <= '0;
        end else if (step) begin
            res[base +: SLICE] <= sum_w[SLICE-1:0];
            carry              <= sum_w[SLICE];
            idx                <= idx + IDXW'(1);
            if (last) begin
                c_out    <= sum_w[SLICE];
                overflow <= cin_msb ^ sum_w[SLICE];
            end
        end
    end

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Scoreboard bench for addsub_nibble_seq: directed corner cases, backpressure,
// mid-operation reset and a randomized stream checked against a reference model.
module tb_addsub_nibble_seq;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NSLICE = 8;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             c_out;
    logic             overflow;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    logic prev_ov  = 1'b0;
    exp_t exp_q[$];
    int   cyc_q[$];

    addsub_nibble_seq #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .c_out(c_out), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model in plain signed/unsigned arithmetic terms
    function automatic exp_t model(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        longint sx, sy, sr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            e.r = x - y;
            e.c = (x >= y);
            sr  = sx - sy;
        end else begin
            e.r = x + y;
            e.c = ({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF;
            sr  = sx + sy;
        end
        e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic c, input logic v);
        exp_t e;
        e.r = r; e.c = c; e.v = v;
        return e;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input exp_t e, output logic acc);
        @(negedge clk);
        in_valid = v; op_sub = s; a = x; b = y;
        acc = v && in_ready;
        if (acc) begin
            exp_q.push_back(e);
            cyc_q.push_back(cyc);
        end
    endtask

    task automatic issue(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input exp_t e);
        logic acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) drive(1'b1, s, x, y, e, acc);
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        drive(1'b0, 1'b0, '0, '0, e, acc);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: owns out_ready, checks latency and pops the scoreboard on handshake
    always @(negedge clk) begin
        exp_t e;
        int   c0;
        case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                if (cyc_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    c0 = cyc_q.pop_front();
                    chk("latency", 64'(cyc - c0), 64'(NSLICE + 1));
                end
            end
            if (out_valid) chk("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res", 64'(res), 64'(e.r));
                    chk("c_out", 64'(c_out), 64'(e.c));
                    chk("overflow", 64'(overflow), 64'(e.v));
                end
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             acc;
        logic [WIDTH-1:0] cap_r;
        logic             cap_c, cap_v;
        logic             s;
        logic [WIDTH-1:0] x, y;
        int               nops, iter, n;

        rst_n = 1'b0; in_valid = 1'b1; op_sub = 1'b0; a = '1; b = '1;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_c_out", 64'(c_out), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Directed corner cases
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1'b1, 1'b0));
        issue(1'b1, 32'h0000_0005, 32'h0000_0003, mk(32'h0000_0002, 1'b1, 1'b0));
        issue(1'b1, 32'h0000_0003, 32'h0000_0005, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
        issue(1'b1, 32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 1'b0, 1'b1));
        wait_drain("drain_directed");

        // Backpressure: result must hold while DONE and inputs are ignored
        @(posedge clk); #1 rdy_mode = 2;
        issue(1'b0, 32'h0000_FFFF, 32'h0001_0001, mk(32'h0002_0000, 1'b0, 1'b0));
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        cap_r = res; cap_c = c_out; cap_v = overflow;
        for (int i = 0; i < 5; i++) begin
            drive(1'(i % 2 == 0), 1'($urandom), $urandom, $urandom, mk('0, 1'b0, 1'b0), acc);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_res", 64'(res), 64'(cap_r));
            chk("bp_hold_flags", 64'({c_out, overflow}), 64'({cap_c, cap_v}));
        end
        drive(1'b0, 1'b0, '0, '0, mk('0, 1'b0, 1'b0), acc);
        @(posedge clk); #1 rdy_mode = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        issue(1'b1, 32'h1234_5678, 32'h0000_0678, mk(32'h1234_5000, 1'b1, 1'b0));
        wait_drain("drain_bp");

        // Reset in the middle of RUN aborts the operation
        issue(1'b0, 32'h1234_5678, 32'h1111_1111, mk(32'h2345_6789, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_res", 64'(res), 64'd0);
        chk("abort_flags", 64'({c_out, overflow}), 64'd0);
        void'(exp_q.pop_back());
        void'(cyc_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(1'b0, 32'h1234_5678, 32'h1111_1111, mk(32'h2345_6789, 1'b0, 1'b0));
        wait_drain("drain_abort");

        // Random stream with random request gaps and random consumer stalls
        @(posedge clk); #1 rdy_mode = 0;
        nops = 0;
        iter = 0;
        while (nops < 1000 && iter < 60000) begin
            s = 1'($urandom);
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = x;
            drive(($urandom_range(0, 2) != 0), s, x, y, model(s, x, y), acc);
            if (acc) nops++;
            iter++;
        end
        chk("random_ops_issued", 64'(nops), 64'd1000);
        drive(1'b0, 1'b0, '0, '0, mk('0, 1'b0, 1'b0), acc);
        wait_drain("drain_random");
        chk("latency_queue_empty", 64'(cyc_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
